// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch sequencer: widths, reset PC,
// debug starvation limit and the FSM state encodings.
package inst_fetch_unit_pkg;

  localparam int AW           = 6;
  localparam int DW           = 32;
  localparam int DBG_MAX_WAIT = 4;
  localparam int CW           = $clog2(DBG_MAX_WAIT + 1);

  // Word 0 of the ROM is reserved empty, so execution starts at word 1.
  localparam logic [AW-1:0] RESET_PC = 6'h01;

  localparam logic [CW-1:0] WAIT_MAX = CW'(DBG_MAX_WAIT);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STEAL = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  // PC increment wraps modulo 2^AW (6'h3F + 1 = 6'h00).
  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return pc + AW'(1);
  endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch sequencer. Owns the address port of the combinational
// instruction ROM, keeps the PC, and registers each fetched word into a
// valid/ready slot for decode. The same ROM port serves a debug readout,
// with a starvation counter that steals a fetch cycle when debug waits
// too long.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RUN   | fetch has ROM priority; debug only gets idle cycles
//   S_STEAL | one cycle where debug owns the ROM, fetch is suspended
//   S_HALT  | halt asserted; no fetching, debug owns the ROM every cycle
//
// A redirect (br_taken) beats everything in every state. If it lands on
// the steal cycle, the steal is retried on the following cycle.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst,
  output logic          if_valid,
  output logic [DW-1:0] if_inst,
  output logic [AW-1:0] if_pc,
  input  logic          if_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          halt,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_data
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          if_valid_q, if_valid_d;
  logic [DW-1:0] if_inst_q, if_inst_d;
  logic [AW-1:0] if_pc_q, if_pc_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] dbg_data_q, dbg_data_d;
  logic [CW-1:0] wait_q, wait_d;

  logic slot_free;
  logic dbg_owns;
  logic do_fetch;
  logic do_dbg;
  logic steal_due;

  // ROM ownership for this cycle: redirect, then debug-owned states,
  // then fetch when the slot can accept, then debug in leftover cycles.
  always_comb begin
    slot_free = !if_valid_q || if_ready;
    dbg_owns  = (state_q == S_STEAL) || (state_q == S_HALT);
    do_fetch  = !br_taken && (state_q == S_RUN) && slot_free;
    do_dbg    = !br_taken && dbg_req && (dbg_owns || !slot_free);
    steal_due = dbg_req && !do_dbg && (wait_q == WAIT_MAX);
  end

  // ROM address mux; parked at the reset PC while reset is held so no
  // debug read can be serviced during reset.
  always_comb begin
    rom_addr = pc_q;
    if (rst) begin
      rom_addr = RESET_PC;
    end else if (br_taken) begin
      rom_addr = br_target;
    end else if (do_dbg) begin
      rom_addr = dbg_addr;
    end
  end

  // Slot and PC update: redirect discards the current slot, fetch loads
  // the next word, otherwise a consumed slot just empties.
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if (br_taken) begin
      if_valid_d = 1'b1;
      if_inst_d  = rom_inst;
      if_pc_d    = br_target;
      pc_d       = pc_inc(br_target);
    end else if (do_fetch) begin
      if_valid_d = 1'b1;
      if_inst_d  = rom_inst;
      if_pc_d    = pc_q;
      pc_d       = pc_inc(pc_q);
    end else if (if_valid_q && if_ready) begin
      if_valid_d = 1'b0;
    end
  end

  // Debug read completion: ack pulses for one cycle, data holds until
  // the next grant.
  always_comb begin
    dbg_ack_d  = do_dbg;
    dbg_data_d = dbg_data_q;
    if (do_dbg) begin
      dbg_data_d = rom_inst;
    end
  end

  // Starvation counter: counts ungranted cycles of a pending request and
  // saturates; any grant (or a withdrawn request) clears it.
  always_comb begin
    wait_d = wait_q;
    if (!dbg_req || do_dbg) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + CW'(1);
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (steal_due) begin
          state_d = S_STEAL;
        end
      end
      S_STEAL: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (br_taken && dbg_req) begin
          state_d = S_STEAL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (!halt) begin
          state_d = steal_due ? S_STEAL : S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
      wait_q     <= wait_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  assign dbg_ack  = dbg_ack_q;
  assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes expected slots and
// debug words into queues, a negedge monitor pops and compares them.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [5:0]  if_pc;
  logic        if_ready;
  logic        br_taken;
  logic [5:0]  br_target;
  logic        halt;
  logic        dbg_req;
  logic [5:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int ack_n;

  logic [37:0] fetch_q[$];
  logic [31:0] dbg_q[$];
  logic [37:0] mon_f;
  logic [31:0] mon_d;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'h00:   return 32'h00000000;
      6'h01:   return 32'h28033046;
      6'h02:   return 32'h00101464;
      6'h03:   return 32'h38000866;
      6'h04:   return 32'h34000489;
      6'h05:   return 32'h3c000c21;
      6'h0A:   return 32'h04100841;
      6'h0B:   return 32'h04200823;
      6'h13:   return 32'h48000001;
      6'h3F:   return 32'h00000000;
      default: return {16'hC0DE, 10'h000, a};
    endcase
  endfunction

  assign rom_inst = rom_word(rom_addr);

  inst_fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .rom_addr (rom_addr),
    .rom_inst (rom_inst),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_pc    (if_pc),
    .if_ready (if_ready),
    .br_taken (br_taken),
    .br_target(br_target),
    .halt     (halt),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_ack  (dbg_ack),
    .dbg_data (dbg_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_f(input logic [5:0] pc, input logic [31:0] inst);
    fetch_q.push_back({pc, inst});
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    if_ready = 1'b0;
    br_taken = 1'b0;
    halt     = 1'b0;
    dbg_req  = 1'b0;
    repeat (2) step();
    rst      = 1'b0;
    if_ready = 1'b1;
  endtask

  // Monitor: compare every consumed slot and every debug ack.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid && if_ready) begin
        if (fetch_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_slot: got pc=%h inst=%h required none", if_pc, if_inst);
        end else begin
          mon_f = fetch_q.pop_front();
          chk("slot_pc", 32'(if_pc), 32'(mon_f[37:32]));
          chk("slot_inst", if_inst, mon_f[31:0]);
        end
      end
      if (dbg_ack) begin
        if (dbg_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got data=%h required none", dbg_data);
        end else begin
          mon_d = dbg_q.pop_front();
          chk("dbg_data", dbg_data, mon_d);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    if_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = 6'h00;
    halt      = 1'b0;
    dbg_req   = 1'b1;
    dbg_addr  = 6'h13;

    // Reset values, with a debug request held during reset.
    repeat (2) step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", 32'(if_pc), 32'h0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_dbg_data", dbg_data, 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h01);
    step();
    chk("rst_ack_held", 32'(dbg_ack), 32'd0);

    // Straight-line fetch, then redirect over an unconsumed slot.
    dbg_req  = 1'b0;
    rst      = 1'b0;
    if_ready = 1'b1;
    push_f(6'h01, 32'h28033046);
    push_f(6'h02, 32'h00101464);
    push_f(6'h03, 32'h38000866);
    push_f(6'h04, 32'h34000489);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("run_valid", 32'(if_valid), 32'd1);
    end
    step();
    chk("pre_redirect_pc", 32'(if_pc), 32'h05);
    if_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 6'h0A;
    push_f(6'h0A, 32'h04100841);
    push_f(6'h0B, 32'h04200823);
    step();
    br_taken = 1'b0;
    if_ready = 1'b1;
    chk("redirect_pc", 32'(if_pc), 32'h0A);
    step();
    step();
    if_ready = 1'b0;

    // Debug read while decode stalls the slot.
    do_reset();
    push_f(6'h01, 32'h28033046);
    step();
    step();
    if_ready = 1'b0;
    dbg_req  = 1'b1;
    dbg_addr = 6'h13;
    dbg_q.push_back(32'h48000001);
    step();
    chk("stall_ack", 32'(dbg_ack), 32'd1);
    chk("stall_slot_pc", 32'(if_pc), 32'h02);
    chk("stall_slot_inst", if_inst, 32'h00101464);
    chk("stall_slot_valid", 32'(if_valid), 32'd1);
    dbg_req = 1'b0;
    step();
    chk("stall_ack_pulse", 32'(dbg_ack), 32'd0);
    chk("stall_slot_hold", 32'(if_pc), 32'h02);
    push_f(6'h02, 32'h00101464);
    push_f(6'h03, 32'h38000866);
    if_ready = 1'b1;
    step();
    step();
    if_ready = 1'b0;

    // Starvation guard: continuous fetch, steal one cycle.
    do_reset();
    push_f(6'h01, 32'h28033046);
    step();
    dbg_req  = 1'b1;
    dbg_addr = 6'h05;
    dbg_q.push_back(32'h3c000c21);
    push_f(6'h02, 32'h00101464);
    push_f(6'h03, 32'h38000866);
    push_f(6'h04, 32'h34000489);
    push_f(6'h05, 32'h3c000c21);
    push_f(6'h06, 32'hC0DE0006);
    ack_n = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (dbg_ack) begin
        ack_n = n;
        break;
      end
      chk("steal_wait_valid", 32'(if_valid), 32'd1);
    end
    chk("steal_ack_edge", 32'(ack_n), 32'd6);
    chk("steal_bubble", 32'(if_valid), 32'd0);
    dbg_req = 1'b0;
    push_f(6'h07, 32'hC0DE0007);
    step();
    chk("steal_resume", 32'(if_valid), 32'd1);
    step();
    if_ready = 1'b0;

    // Redirect to the top word, PC wraps to 0.
    do_reset();
    push_f(6'h01, 32'h28033046);
    step();
    br_taken  = 1'b1;
    br_target = 6'h3F;
    push_f(6'h3F, 32'h00000000);
    push_f(6'h00, 32'h00000000);
    push_f(6'h01, 32'h28033046);
    step();
    br_taken = 1'b0;
    chk("wrap_slot_pc", 32'(if_pc), 32'h3F);
    step();
    step();
    step();
    if_ready = 1'b0;

    // Halt: redirect still applies, fetch freezes, debug served at once.
    do_reset();
    push_f(6'h01, 32'h28033046);
    step();
    halt = 1'b1;
    push_f(6'h02, 32'h00101464);
    step();
    br_taken  = 1'b1;
    br_target = 6'h0A;
    push_f(6'h0A, 32'h04100841);
    step();
    br_taken = 1'b0;
    if_ready = 1'b0;
    dbg_req  = 1'b1;
    dbg_addr = 6'h03;
    dbg_q.push_back(32'h38000866);
    chk("halt_redirect_pc", 32'(if_pc), 32'h0A);
    step();
    chk("halt_dbg_ack", 32'(dbg_ack), 32'd1);
    chk("halt_slot_valid", 32'(if_valid), 32'd1);
    dbg_req = 1'b0;
    step();
    chk("halt_frozen_pc", 32'(if_pc), 32'h0A);
    chk("halt_ack_pulse", 32'(dbg_ack), 32'd0);
    if_ready = 1'b1;
    step();
    chk("halt_no_fetch", 32'(if_valid), 32'd0);
    halt = 1'b0;
    step();
    chk("unhalt_no_fetch_yet", 32'(if_valid), 32'd0);
    push_f(6'h0B, 32'h04200823);
    step();
    chk("unhalt_fetch", 32'(if_valid), 32'd1);
    step();
    if_ready = 1'b0;

    // Reset mid-stream with a pending debug request.
    dbg_req  = 1'b1;
    dbg_addr = 6'h13;
    if_ready = 1'b1;
    push_f(6'h0C, 32'hC0DE000C);
    push_f(6'h0D, 32'hC0DE000D);
    step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_inst", if_inst, 32'h0);
    chk("mid_rst_pc", 32'(if_pc), 32'h0);
    chk("mid_rst_ack", 32'(dbg_ack), 32'd0);
    chk("mid_rst_dbg_data", dbg_data, 32'h0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'h01);
    repeat (3) begin
      step();
      chk("mid_rst_no_ack", 32'(dbg_ack), 32'd0);
    end
    dbg_req = 1'b0;
    rst     = 1'b0;
    push_f(6'h01, 32'h28033046);
    step();
    chk("post_rst_valid", 32'(if_valid), 32'd1);
    chk("post_rst_no_ack", 32'(dbg_ack), 32'd0);
    step();
    if_ready = 1'b0;
    repeat (2) step();

    chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
